// File: rtl/align_shifter_pipe_if.sv
// Beat handshake bundle for align_shifter_pipe: upstream valid/ready beat in, aligned beat out.
// in_left exists only when ALIGN_SHIFT_LEFT_EN is defined.
interface align_shifter_pipe_if #(
  parameter int WIDTH   = 24,
  parameter int SHIFT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_mant;
  logic [SHIFT_W-1:0] in_shamt;
  logic [7:0]         in_tag;
`ifdef ALIGN_SHIFT_LEFT_EN
  logic               in_left;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_mant;
  logic [2:0]         out_grs;
  logic [7:0]         out_tag;

  modport master (
`ifdef ALIGN_SHIFT_LEFT_EN
    output in_left,
`endif
    output in_valid, in_mant, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_mant, out_grs, out_tag
  );

  modport slave (
`ifdef ALIGN_SHIFT_LEFT_EN
    input  in_left,
`endif
    input  in_valid, in_mant, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_mant, out_grs, out_tag
  );
endinterface

// File: rtl/align_shifter_pipe.sv
// Pipelined right-align barrel shifter with guard/round/sticky and shift saturation; ALIGN_SHIFT_LEFT_EN adds left shifts.
// Latency: STAGES cycles from accept to out_valid, 1 beat/cycle.
// Backpressure: per-stage load = !valid || downstream load; in_ready is combinational from out_ready, no skid buffer.
module align_shifter_pipe #(
  parameter int WIDTH   = 24,
  parameter int SHIFT_W = 8,
  parameter int STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  align_shifter_pipe_if.slave io
);
  localparam int EXT_W  = WIDTH + 3;
  localparam int LEVELS = $clog2(EXT_W);
  // Wide enough to hold both the raw shift amount and the EXT_W threshold.
  localparam int AW     = (SHIFT_W > LEVELS) ? SHIFT_W : LEVELS + 1;
  localparam int BASE   = LEVELS / STAGES;
  localparam int EXTRA  = LEVELS % STAGES;

  typedef struct packed {
    logic [EXT_W-1:0]  ext;
    logic              sticky;
    logic [LEVELS-1:0] amt;
    logic [7:0]        tag;
`ifdef ALIGN_SHIFT_LEFT_EN
    logic              left;
`endif
  } beat_t;

  function automatic int stage_of_level(int l);
    int first;
    int cnt;
    stage_of_level = STAGES - 1;
    for (int s = 0; s < STAGES; s++) begin
      first = s * BASE + ((s < EXTRA) ? s : EXTRA);
      cnt   = BASE + ((s < EXTRA) ? 1 : 0);
      if (l >= first && l < first + cnt) stage_of_level = s;
    end
  endfunction

  function automatic logic [EXT_W-1:0] low_mask(int k);
    if (k >= EXT_W) low_mask = '1;
    else            low_mask = (EXT_W'(1) << k) - EXT_W'(1);
  endfunction

  logic [STAGES-1:0]  vld;
  logic [STAGES-1:0]  ld;
  beat_t [STAGES-1:0] r;
  beat_t [STAGES-1:0] nxt;
  beat_t              in_beat;
  logic [AW-1:0]      amt_w;

  assign amt_w = AW'(io.in_shamt);

  // Saturated shifts are resolved here so the levels only ever see amounts below 2^LEVELS.
  always_comb begin
    in_beat        = '0;
    in_beat.ext    = {io.in_mant, 3'b000};
    in_beat.amt    = amt_w[LEVELS-1:0];
    in_beat.tag    = io.in_tag;
`ifdef ALIGN_SHIFT_LEFT_EN
    in_beat.left   = io.in_left;
    if (io.in_left) begin
      if (amt_w >= AW'(WIDTH)) in_beat.ext = '0;
    end else
`endif
    if (amt_w >= AW'(EXT_W)) begin
      in_beat.ext    = '0;
      in_beat.sticky = |io.in_mant;
    end
  end

  always_comb begin : p_levels
    beat_t cur;
    int    k;
    cur = '0;
    k   = 0;
    nxt = '0;
    for (int s = 0; s < STAGES; s++) begin
      cur = (s == 0) ? in_beat : r[s-1];
      for (int l = 0; l < LEVELS; l++) begin
        if (stage_of_level(l) == s && cur.amt[LEVELS-1-l]) begin
          k = 1 << (LEVELS - 1 - l);
`ifdef ALIGN_SHIFT_LEFT_EN
          if (cur.left) begin
            cur.ext = cur.ext << k;
          end else
`endif
          begin
            cur.sticky = cur.sticky | (|(cur.ext & low_mask(k)));
            cur.ext    = cur.ext >> k;
          end
        end
      end
      nxt[s] = cur;
    end
  end

  // A stage can load when it, or any stage after it, has a free slot, or the sink drains.
  always_comb begin : p_ready
    logic [STAGES-1:0] full_from;
    full_from = '0;
    ld        = '0;
    for (int s = 0; s < STAGES; s++) begin
      full_from = vld | STAGES'((1 << s) - 1);
      ld[s]     = io.out_ready || !(&full_from);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      r   <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (ld[s]) begin
          vld[s] <= (s == 0) ? io.in_valid : vld[s-1];
          if ((s == 0) ? io.in_valid : vld[s-1]) r[s] <= nxt[s];
        end
      end
    end
  end

  assign io.in_ready  = ld[0];
  assign io.out_valid = vld[STAGES-1];
  assign io.out_mant  = r[STAGES-1].ext[EXT_W-1:3];
  assign io.out_grs   = {r[STAGES-1].ext[2], r[STAGES-1].ext[1],
                         r[STAGES-1].ext[0] | r[STAGES-1].sticky};
  assign io.out_tag   = r[STAGES-1].tag;

  logic unused_tail;
`ifdef ALIGN_SHIFT_LEFT_EN
  assign unused_tail = ^{r[STAGES-1].amt, r[STAGES-1].left};
`else
  assign unused_tail = ^r[STAGES-1].amt;
`endif
endmodule
